rvjtag_dtm: RTL and testbench



---
 rtl/rvjtag_pkg.sv | 34 +++
 rtl/rvjtag_tap_fsm.sv | 82 ++++++++
 rtl/rvjtag_dtm.sv | 197 +++++++++++++++++++
 tb/tb_rvjtag_dtm.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvjtag_pkg.sv
// Shared types and constants for the RISC-V JTAG debug transport module.
package rvjtag_pkg;

    typedef enum logic [3:0] {
        TAP_RESET,
        TAP_IDLE,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_t;

    localparam logic [4:0] OPC_IDCODE = 5'h01;
    localparam logic [4:0] OPC_DTMCS  = 5'h10;
    localparam logic [4:0] OPC_DMI    = 5'h11;

    localparam int DTMCS_DMI_RESET_BIT  = 16;
    localparam int DTMCS_HARD_RESET_BIT = 17;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

endpackage

// File: rtl/rvjtag_tap_fsm.sv
// IEEE 1149.1 TAP controller; advances only on the oversampled tck rising strobe.
//
// state        | meaning
// TAP_RESET    | Test-Logic-Reset, IR forced to default
// TAP_IDLE     | Run-Test/Idle
// TAP_SEL_DR   | Select-DR-Scan
// TAP_CAP_DR   | Capture-DR, selected data register loads on next rise
// TAP_SHIFT_DR | Shift-DR, data register shifts on each rise
// TAP_EXIT1_DR | Exit1-DR
// TAP_PAUSE_DR | Pause-DR
// TAP_EXIT2_DR | Exit2-DR
// TAP_UPD_DR   | Update-DR, data register acted on at tck fall
// TAP_SEL_IR   | Select-IR-Scan
// TAP_CAP_IR   | Capture-IR
// TAP_SHIFT_IR | Shift-IR
// TAP_EXIT1_IR | Exit1-IR
// TAP_PAUSE_IR | Pause-IR
// TAP_EXIT2_IR | Exit2-IR
// TAP_UPD_IR   | Update-IR, IR loaded at tck fall
module rvjtag_tap_fsm
    import rvjtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tck_rise,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    tap_state_t state_nxt;

    // State register, stepped once per tck rise
    always_ff @(posedge clock) begin
        if (reset)
            state <= TAP_RESET;
        else if (tck_rise)
            state <= state_nxt;
    end

    // Standard 1149.1 transitions plus one-hot phase flags
    always_comb begin
        state_nxt  = state;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        case (state)
            TAP_RESET:    state_nxt = tms ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     state_nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   state_nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   state_nxt = tms ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            default:      state_nxt = TAP_RESET;
        endcase
        capture_dr = (state == TAP_CAP_DR);
        shift_dr   = (state == TAP_SHIFT_DR);
        update_dr  = (state == TAP_UPD_DR);
        capture_ir = (state == TAP_CAP_IR);
        shift_ir   = (state == TAP_SHIFT_IR);
        update_ir  = (state == TAP_UPD_IR);
    end

endmodule

// File: rtl/rvjtag_dtm.sv
// RISC-V JTAG DTM: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS registers and
// single-clock DMI request pulses. Define RVJTAG_IDCODE_EN to include IDCODE.
module rvjtag_dtm
    import rvjtag_pkg::*;
#(
    parameter int ABITS       = 7,
    parameter int IR_LEN      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_tck,
    input  logic             io_tms,
    input  logic             io_tdi,
    input  logic [31:0]      io_rd_data,
    input  logic [1:0]       io_rd_status,
    input  logic [2:0]       io_idle,
    input  logic [1:0]       io_dmi_stat,
    input  logic [3:0]       io_version,
    input  logic [31:0]      io_jtag_id,
    output logic             io_tdo,
    output logic             io_tdoEnable,
    output logic [31:0]      io_wr_data,
    output logic [ABITS-1:0] io_wr_addr,
    output logic             io_wr_en,
    output logic             io_rd_en,
    output logic             io_dmi_reset,
    output logic             io_dmi_hard_reset
);

    localparam int DMI_W = ABITS + 34;
`ifdef RVJTAG_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_DEFAULT = IR_LEN'(OPC_IDCODE);
`else
    localparam logic [IR_LEN-1:0] IR_DEFAULT = '1;
`endif

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic tck_d, tms_d, tdi_d;
    logic tck_rise, tck_fall;

    tap_state_t state;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    logic [IR_LEN-1:0] ir, ir_sr;
    logic              bypass_sr;
    logic [31:0]       dtmcs_sr;
    logic [DMI_W-1:0]  dmi_sr;
    logic              sel_dtmcs, sel_dmi, sel_idcode, dr_lsb;
    logic [1:0]        dmi_op;

    // Pin synchronisers; tms/tdi carry the same extra flop as tck so an edge
    // and a simultaneous tms change resolve to the pre-change tms
    always_ff @(posedge clock) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_d    <= 1'b0;
            tms_d    <= 1'b0;
            tdi_d    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], io_tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], io_tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], io_tdi};
            tck_d    <= tck_sync[SYNC_STAGES-1];
            tms_d    <= tms_sync[SYNC_STAGES-1];
            tdi_d    <= tdi_sync[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_d;
    assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_d;

    rvjtag_tap_fsm u_tap (
        .clock      (clock),
        .reset      (reset),
        .tck_rise   (tck_rise),
        .tms        (tms_d),
        .state      (state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    assign sel_dtmcs = (ir == IR_LEN'(OPC_DTMCS));
    assign sel_dmi   = (ir == IR_LEN'(OPC_DMI));
    assign dmi_op    = dmi_sr[1:0];

`ifdef RVJTAG_IDCODE_EN
    logic [31:0] idcode_sr;
    assign sel_idcode = (ir == IR_LEN'(OPC_IDCODE));
`else
    logic unused_jtag_id;
    assign sel_idcode     = 1'b0;
    assign unused_jtag_id = ^io_jtag_id;
`endif

    // LSB of the data register currently selected by IR
    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_dtmcs)
            dr_lsb = dtmcs_sr[0];
        else if (sel_dmi)
            dr_lsb = dmi_sr[0];
`ifdef RVJTAG_IDCODE_EN
        else if (sel_idcode)
            dr_lsb = idcode_sr[0];
`endif
    end

    // IR and data registers: capture/shift on tck rise, IR update on tck fall
    always_ff @(posedge clock) begin
        if (reset) begin
            ir        <= IR_DEFAULT;
            ir_sr     <= '0;
            bypass_sr <= 1'b0;
            dtmcs_sr  <= '0;
            dmi_sr    <= '0;
`ifdef RVJTAG_IDCODE_EN
            idcode_sr <= '0;
`endif
        end else begin
            if (state == TAP_RESET)
                ir <= IR_DEFAULT;
            else if (tck_fall && update_ir)
                ir <= ir_sr;
            if (tck_rise) begin
                if (capture_ir)
                    ir_sr <= IR_LEN'(2'b01);
                else if (shift_ir)
                    ir_sr <= {tdi_d, ir_sr[IR_LEN-1:1]};
                if (capture_dr) begin
                    if (sel_dtmcs)
                        dtmcs_sr <= {14'd0, 2'b00, 1'b0, io_idle, io_dmi_stat, 6'(ABITS), io_version};
                    else if (sel_dmi)
                        dmi_sr <= {{ABITS{1'b0}}, io_rd_data, io_rd_status};
`ifdef RVJTAG_IDCODE_EN
                    else if (sel_idcode)
                        idcode_sr <= io_jtag_id;
`endif
                    else
                        bypass_sr <= 1'b0;
                end else if (shift_dr) begin
                    if (sel_dtmcs)
                        dtmcs_sr <= {tdi_d, dtmcs_sr[31:1]};
                    else if (sel_dmi)
                        dmi_sr <= {tdi_d, dmi_sr[DMI_W-1:1]};
`ifdef RVJTAG_IDCODE_EN
                    else if (sel_idcode)
                        idcode_sr <= {tdi_d, idcode_sr[31:1]};
`endif
                    else
                        bypass_sr <= tdi_d;
                end
            end
        end
    end

    // tdo and request outputs, all driven from the tck fall strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            io_tdo            <= 1'b0;
            io_tdoEnable      <= 1'b0;
            io_wr_data        <= '0;
            io_wr_addr        <= '0;
            io_wr_en          <= 1'b0;
            io_rd_en          <= 1'b0;
            io_dmi_reset      <= 1'b0;
            io_dmi_hard_reset <= 1'b0;
        end else begin
            io_wr_en          <= 1'b0;
            io_rd_en          <= 1'b0;
            io_dmi_reset      <= 1'b0;
            io_dmi_hard_reset <= 1'b0;
            if (tck_fall) begin
                io_tdoEnable <= shift_ir | shift_dr;
                io_tdo       <= shift_ir ? ir_sr[0] : (shift_dr ? dr_lsb : 1'b0);
                if (update_dr && sel_dtmcs) begin
                    io_dmi_reset      <= dtmcs_sr[DTMCS_DMI_RESET_BIT];
                    io_dmi_hard_reset <= dtmcs_sr[DTMCS_HARD_RESET_BIT];
                end
                if (update_dr && sel_dmi &&
                    (dmi_op == DMI_OP_READ || dmi_op == DMI_OP_WRITE)) begin
                    io_wr_addr <= dmi_sr[DMI_W-1:34];
                    io_wr_data <= dmi_sr[33:2];
                    io_rd_en   <= (dmi_op == DMI_OP_READ);
                    io_wr_en   <= (dmi_op == DMI_OP_WRITE);
                end
            end
        end
    end

endmodule

// File: tb/tb_rvjtag_dtm.sv
// Self-checking bench for rvjtag_dtm: directed vector table, hand sequences
// for reset corners, and randomized scans against a transaction-level model.
module tb_rvjtag_dtm;

    localparam int PH = 5;   // clocks per tck phase

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_tck = 1'b0, io_tms = 1'b0, io_tdi = 1'b0;
    logic [31:0] io_rd_data = '0;
    logic [1:0]  io_rd_status = '0;
    logic [2:0]  io_idle = '0;
    logic [1:0]  io_dmi_stat = '0;
    logic [3:0]  io_version = '0;
    logic [31:0] io_jtag_id = 32'h1000_08B5;
    logic        io_tdo, io_tdoEnable, io_wr_en, io_rd_en, io_dmi_reset, io_dmi_hard_reset;
    logic [31:0] io_wr_data;
    logic [6:0]  io_wr_addr;

    int n_cmp = 0, n_bad = 0;
    int n_wr = 0, n_rd = 0, n_dr = 0, n_hr = 0;

    rvjtag_dtm dut (
        .clock             (clock),
        .reset             (reset),
        .io_tck            (io_tck),
        .io_tms            (io_tms),
        .io_tdi            (io_tdi),
        .io_rd_data        (io_rd_data),
        .io_rd_status      (io_rd_status),
        .io_idle           (io_idle),
        .io_dmi_stat       (io_dmi_stat),
        .io_version        (io_version),
        .io_jtag_id        (io_jtag_id),
        .io_tdo            (io_tdo),
        .io_tdoEnable      (io_tdoEnable),
        .io_wr_data        (io_wr_data),
        .io_wr_addr        (io_wr_addr),
        .io_wr_en          (io_wr_en),
        .io_rd_en          (io_rd_en),
        .io_dmi_reset      (io_dmi_reset),
        .io_dmi_hard_reset (io_dmi_hard_reset)
    );

    always #5 clock = ~clock;

    // Count clocks each pulse output is high; a one-clock pulse adds exactly 1
    always @(negedge clock) begin
        if (io_wr_en)          n_wr++;
        if (io_rd_en)          n_rd++;
        if (io_dmi_reset)      n_dr++;
        if (io_dmi_hard_reset) n_hr++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v,
                             output logic tdo_v, output logic en_v);
        io_tms = tms_v;
        io_tdi = tdi_v;
        repeat (PH) @(negedge clock);
        tdo_v  = io_tdo;
        en_v   = io_tdoEnable;
        io_tck = 1'b1;
        repeat (PH) @(negedge clock);
        io_tck = 1'b0;
    endtask

    task automatic go_idle();
        logic t, e;
        tck_cycle(1'b0, 1'b0, t, e);
    endtask

    task automatic go_reset();
        logic t, e;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, t, e);
    endtask

    // From Run-Test/Idle: load IR, return the captured IR bits
    task automatic scan_ir(input logic [4:0] op, output logic [4:0] cap);
        logic t, e;
        cap = '0;
        tck_cycle(1'b1, 1'b0, t, e);
        tck_cycle(1'b1, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, t, e);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, op[i], t, e);
            cap[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, t, e);
        repeat (2 * PH) @(negedge clock);
    endtask

    // From Run-Test/Idle: n-bit DR scan; en_ok requires enable high only while shifting
    task automatic scan_dr(input logic [63:0] din, input int n,
                           output logic [63:0] dout, output logic en_ok);
        logic t, e;
        dout  = '0;
        en_ok = 1'b1;
        tck_cycle(1'b1, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, t, e);
        en_ok &= ~e;
        tck_cycle(1'b0, 1'b0, t, e);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t, e);
            dout[i] = t;
            en_ok &= e;
        end
        tck_cycle(1'b1, 1'b0, t, e);
        en_ok &= ~e;
        tck_cycle(1'b0, 1'b0, t, e);
        repeat (2 * PH) @(negedge clock);
    endtask

    task automatic run_dr(input string name, input logic [63:0] din, input int n,
                          input logic [63:0] exp_dout, input int ewr, input int erd,
                          input int edr, input int ehr);
        logic [63:0] dout;
        logic        en_ok;
        int b_wr, b_rd, b_dr, b_hr;
        b_wr = n_wr; b_rd = n_rd; b_dr = n_dr; b_hr = n_hr;
        scan_dr(din, n, dout, en_ok);
        check({name, " dout"}, dout, exp_dout);
        check({name, " tdo_enable"}, 64'(en_ok), 64'd1);
        check({name, " wr_en pulses"}, 64'(n_wr - b_wr), 64'(ewr));
        check({name, " rd_en pulses"}, 64'(n_rd - b_rd), 64'(erd));
        check({name, " dmi_reset pulses"}, 64'(n_dr - b_dr), 64'(edr));
        check({name, " hard_reset pulses"}, 64'(n_hr - b_hr), 64'(ehr));
    endtask

    typedef struct {
        logic [4:0]  ir;
        int          n;
        logic [63:0] din;
        logic [31:0] rd_data;
        logic [1:0]  rd_status;
        logic [2:0]  idle;
        logic [1:0]  stat;
        logic [3:0]  ver;
        logic [63:0] exp_dout;
        int          ewr, erd, edr, ehr;
        logic [6:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    logic [63:0] exp_default;
    logic [4:0]  irc;
    logic [63:0] din, mask, exp_d;
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  op;
    logic [4:0]  opc;
    int          nb;

    initial begin
`ifdef RVJTAG_IDCODE_EN
        exp_default = 64'h1000_08B5;
`else
        exp_default = 64'hFFFF_FFFE;
`endif
        //            ir     n   din                                    rd_data       st     idle  stat  ver    exp_dout                                wr rd dr hr addr   data
        vecs[0] = '{5'h10, 32, 64'h0,                                32'h0,        2'd0, 3'd5, 2'd1, 4'h1, 64'h5471,                               0, 0, 0, 0, 7'h00, 32'h0};
        vecs[1] = '{5'h10, 32, 64'h2_0000,                           32'h0,        2'd0, 3'd0, 2'd0, 4'h0, 64'h0070,                               0, 0, 0, 1, 7'h00, 32'h0};
        vecs[2] = '{5'h10, 32, 64'h1_0000,                           32'h0,        2'd0, 3'd7, 2'd3, 4'hF, 64'h7C7F,                               0, 0, 1, 0, 7'h00, 32'h0};
        vecs[3] = '{5'h11, 41, {23'b0, 7'h10, 32'hDEADBEEF, 2'b10},  32'hA5A50F0F, 2'd1, 3'd0, 2'd0, 4'h0, {30'b0, 32'hA5A50F0F, 2'b01},          1, 0, 0, 0, 7'h10, 32'hDEADBEEF};
        vecs[4] = '{5'h11, 41, {23'b0, 7'h11, 32'h0, 2'b01},         32'hCAFE0000, 2'd2, 3'd0, 2'd0, 4'h0, {30'b0, 32'hCAFE0000, 2'b10},          0, 1, 0, 0, 7'h11, 32'h0};
        vecs[5] = '{5'h11, 41, {23'b0, 7'h7F, 32'hFFFFFFFF, 2'b00},  32'h12345678, 2'd0, 3'd0, 2'd0, 4'h0, {30'b0, 32'h12345678, 2'b00},          0, 0, 0, 0, 7'h11, 32'h0};
        vecs[6] = '{5'h11, 41, {23'b0, 7'h05, 32'h5555, 2'b11},      32'hFFFFFFFF, 2'd3, 3'd0, 2'd0, 4'h0, {30'b0, 32'hFFFFFFFF, 2'b11},          0, 0, 0, 0, 7'h11, 32'h0};
        vecs[7] = '{5'h15, 8,  64'hA5,                               32'h0,        2'd0, 3'd0, 2'd0, 4'h0, 64'h4A,                                 0, 0, 0, 0, 7'h11, 32'h0};
        vecs[8] = '{5'h01, 32, 64'hFFFF_FFFF,                        32'h0,        2'd0, 3'd0, 2'd0, 4'h0, exp_default,                            0, 0, 0, 0, 7'h11, 32'h0};
        vecs[9] = '{5'h1F, 1,  64'h1,                                32'h0,        2'd0, 3'd0, 2'd0, 4'h0, 64'h0,                                  0, 0, 0, 0, 7'h11, 32'h0};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset outputs",
              {19'b0, io_tdo, io_tdoEnable, io_wr_en, io_rd_en, io_dmi_reset, io_dmi_hard_reset, io_wr_addr, io_wr_data},
              64'h0);

        // IR default after reset: IDCODE with the macro, BYPASS without
        go_idle();
        run_dr("reset default ir", 64'hFFFF_FFFF, 32, exp_default, 0, 0, 0, 0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            scan_ir(vecs[i].ir, irc);
            check($sformatf("vec%0d ir_capture", i), 64'(irc), 64'h1);
            io_rd_data   = vecs[i].rd_data;
            io_rd_status = vecs[i].rd_status;
            io_idle      = vecs[i].idle;
            io_dmi_stat  = vecs[i].stat;
            io_version   = vecs[i].ver;
            run_dr($sformatf("vec%0d", i), vecs[i].din, vecs[i].n, vecs[i].exp_dout,
                   vecs[i].ewr, vecs[i].erd, vecs[i].edr, vecs[i].ehr);
            check($sformatf("vec%0d wr_addr", i), 64'(io_wr_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d wr_data", i), 64'(io_wr_data), 64'(vecs[i].exp_data));
        end

        // Test-Logic-Reset via tms restores default IR, no pulses
        scan_ir(5'h10, irc);
        go_reset();
        run_dr("tlr default ir", 64'hFFFF_FFFF, 32, exp_default, 0, 0, 0, 0);

        // Randomized scans against a transaction-level model
        m_addr = 7'h11;
        m_data = 32'h0;
        for (int it = 0; it < 24; it++) begin
            io_idle      = 3'($urandom_range(0, 7));
            io_dmi_stat  = 2'($urandom_range(0, 3));
            io_version   = 4'($urandom_range(0, 15));
            io_rd_data   = $urandom;
            io_rd_status = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin
                    scan_ir(5'h10, irc);
                    din   = 64'($urandom);
                    exp_d = 64'(io_idle) * 4096 + 64'(io_dmi_stat) * 1024 + 64'd7 * 16 + 64'(io_version);
                    run_dr($sformatf("rand%0d dtmcs", it), din, 32, exp_d, 0, 0,
                           int'(din[16]), int'(din[17]));
                end
                1, 2: begin
                    scan_ir(5'h11, irc);
                    op    = 2'($urandom_range(0, 3));
                    din   = {23'b0, 7'($urandom_range(0, 127)), 32'($urandom), op};
                    exp_d = 64'(io_rd_data) * 4 + 64'(io_rd_status);
                    if (op == 2'd1 || op == 2'd2) begin
                        m_addr = din[40:34];
                        m_data = din[33:2];
                    end
                    run_dr($sformatf("rand%0d dmi op%0d", it, op), din, 41, exp_d,
                           int'(op == 2'd2), int'(op == 2'd1), 0, 0);
                    check($sformatf("rand%0d wr_addr", it), 64'(io_wr_addr), 64'(m_addr));
                    check($sformatf("rand%0d wr_data", it), 64'(io_wr_data), 64'(m_data));
                end
                default: begin
                    do opc = 5'($urandom_range(0, 31));
                    while (opc == 5'h01 || opc == 5'h10 || opc == 5'h11);
                    scan_ir(opc, irc);
                    nb    = $urandom_range(1, 16);
                    mask  = (64'd1 << nb) - 64'd1;
                    din   = 64'($urandom) & mask;
                    exp_d = (din << 1) & mask;
                    run_dr($sformatf("rand%0d bypass ir%0h", it, opc), din, nb, exp_d, 0, 0, 0, 0);
                end
            endcase
        end

        // Reset asserted mid Shift-DR with non-zero DMI outputs
        scan_ir(5'h11, irc);
        run_dr("pre-reset write", {23'b0, 7'h2A, 32'h0BAD_F00D, 2'b10}, 41,
               64'(io_rd_data) * 4 + 64'(io_rd_status), 1, 0, 0, 0);
        begin
            logic t, e;
            tck_cycle(1'b1, 1'b0, t, e);
            tck_cycle(1'b0, 1'b0, t, e);
            tck_cycle(1'b0, 1'b0, t, e);
            for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, t, e);
            repeat (PH) @(negedge clock);
            check("mid-shift enable", 64'(io_tdoEnable), 64'd1);
        end
        reset = 1'b1;
        @(negedge clock);
        check("reset mid-shift outputs",
              {19'b0, io_tdo, io_tdoEnable, io_wr_en, io_rd_en, io_dmi_reset, io_dmi_hard_reset, io_wr_addr, io_wr_data},
              64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        go_idle();
        run_dr("post-reset default ir", 64'hFFFF_FFFF, 32, exp_default, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
